// File: rtl/edge_det_pkg.sv
// Shared types and sizing helpers for the edge-detector scan path.
package edge_det_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    PRESENT,
    WAIT_RES,
    WRITE,
    DONE
  } scan_state_t;

  // Bits needed to address 0 .. max(wd, ht)-1; never less than one bit.
  function automatic int coord_bits_for(input int wd, input int ht);
    int max_dim;
    max_dim = (wd > ht) ? wd : ht;
    return (max_dim <= 2) ? 1 : $clog2(max_dim);
  endfunction

  // Width of a flattened WIN_HT x WIN_WD window of PXL_BITS pixels.
  function automatic int win_flat_bits(input int win_ht, input int win_wd, input int pxl_bits);
    return win_ht * win_wd * pxl_bits;
  endfunction

endpackage

// File: rtl/raster_coord_ctr.sv
// Raster-order (x, y) walker. Holds at the last coordinate of the frame.
module raster_coord_ctr #(
  parameter int IMG_WD     = 4,
  parameter int IMG_HT     = 3,
  parameter int COORD_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  adv,
  output logic [COORD_BITS-1:0] cur_x,
  output logic [COORD_BITS-1:0] cur_y,
  output logic                  is_last
);

  localparam logic [COORD_BITS-1:0] LAST_X = COORD_BITS'(IMG_WD - 1);
  localparam logic [COORD_BITS-1:0] LAST_Y = COORD_BITS'(IMG_HT - 1);

  assign is_last = (cur_x == LAST_X) && (cur_y == LAST_Y);

  // Clear to origin, or step one pixel in raster order unless already at the end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_x <= '0;
      cur_y <= '0;
    end else if (clr) begin
      cur_x <= '0;
      cur_y <= '0;
    end else if (adv && !is_last) begin
      if (cur_x < LAST_X) begin
        cur_x <= cur_x + 1'b1;
      end else begin
        cur_x <= '0;
        cur_y <= cur_y + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_scan_ctrl.sv
// Raster-scan sequencer: read window, hand to kernel, write result back.
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | waiting for start
// READ     | source window read at cur_x/cur_y, captured at edge
// PRESENT  | window offered to kernel until win_rdy
// WAIT_RES | waiting for kernel result, captured on res_vld
// WRITE    | result written at cur_x/cur_y, coordinates advance
// DONE     | one-cycle done pulse after the last write
module frame_scan_ctrl
  import edge_det_pkg::*;
#(
  parameter int IMG_WD     = 4,
  parameter int IMG_HT     = 3,
  parameter int COORD_BITS = coord_bits_for(IMG_WD, IMG_HT),
  parameter int WIN_WD     = 3,
  parameter int WIN_HT     = 3,
  parameter int PXL_BITS   = 12
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic                                    abort,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    fb_rd_en,
  output logic [COORD_BITS-1:0]                   fb_rd_x,
  output logic [COORD_BITS-1:0]                   fb_rd_y,
  input  logic [win_flat_bits(WIN_HT, WIN_WD, PXL_BITS)-1:0] fb_rd_data_flat,
  output logic                                    win_vld,
  input  logic                                    win_rdy,
  output logic [win_flat_bits(WIN_HT, WIN_WD, PXL_BITS)-1:0] win_data_flat,
  input  logic                                    res_vld,
  output logic                                    res_rdy,
  input  logic signed [PXL_BITS-1:0]              res_data,
  output logic                                    fb_wr_en,
  output logic [COORD_BITS-1:0]                   fb_wr_x,
  output logic [COORD_BITS-1:0]                   fb_wr_y,
  output logic signed [PXL_BITS-1:0]              fb_wr_data
);

  scan_state_t state, state_nxt;
  logic                  coord_clr;
  logic                  coord_adv;
  logic                  is_last;
  logic [COORD_BITS-1:0] cur_x;
  logic [COORD_BITS-1:0] cur_y;

  raster_coord_ctr #(
    .IMG_WD     (IMG_WD),
    .IMG_HT     (IMG_HT),
    .COORD_BITS (COORD_BITS)
  ) u_coord (
    .clk     (clk),
    .rst     (rst),
    .clr     (coord_clr),
    .adv     (coord_adv),
    .cur_x   (cur_x),
    .cur_y   (cur_y),
    .is_last (is_last)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; abort from any active state returns to IDLE.
  always_comb begin
    state_nxt = state;
    coord_clr = 1'b0;
    coord_adv = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = READ;
          coord_clr = 1'b1;
        end
      end
      READ:     state_nxt = abort ? IDLE : PRESENT;
      PRESENT: begin
        if (abort)        state_nxt = IDLE;
        else if (win_rdy) state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        if (abort)        state_nxt = IDLE;
        else if (res_vld) state_nxt = WRITE;
      end
      WRITE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          coord_adv = 1'b1;
          state_nxt = is_last ? DONE : READ;
        end
      end
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign fb_rd_en = (state == READ);
  assign win_vld  = (state == PRESENT);
  assign res_rdy  = (state == WAIT_RES);
  assign fb_wr_en = (state == WRITE);
  assign fb_rd_x  = fb_rd_en ? cur_x : '0;
  assign fb_rd_y  = fb_rd_en ? cur_y : '0;
  assign fb_wr_x  = fb_wr_en ? cur_x : '0;
  assign fb_wr_y  = fb_wr_en ? cur_y : '0;

  // Capture the source window in READ and the kernel result on its handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_data_flat <= '0;
      fb_wr_data    <= '0;
    end else begin
      if (state == READ) win_data_flat <= fb_rd_data_flat;
      if ((state == WAIT_RES) && res_vld && !abort) fb_wr_data <= res_data;
    end
  end

endmodule

// File: tb/tb_frame_scan_ctrl.sv
// Directed bench for frame_scan_ctrl: 4x3 frame scans plus a 1x1 instance.
module tb_frame_scan_ctrl;

  localparam int FW = 108;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- 4x3 instance ----------------
  logic          start = 1'b0, abort = 1'b0;
  logic          busy, done, fb_rd_en, win_vld, res_rdy, fb_wr_en;
  logic [1:0]    fb_rd_x, fb_rd_y, fb_wr_x, fb_wr_y;
  logic [FW-1:0] fb_rd_data_flat, win_data_flat;
  logic          win_rdy = 1'b1;
  logic          res_vld;
  logic [11:0]   res_data, fb_wr_data;

  frame_scan_ctrl #(.IMG_WD(4), .IMG_HT(3), .WIN_WD(3), .WIN_HT(3), .PXL_BITS(12)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .fb_rd_en(fb_rd_en), .fb_rd_x(fb_rd_x), .fb_rd_y(fb_rd_y),
    .fb_rd_data_flat(fb_rd_data_flat), .win_vld(win_vld), .win_rdy(win_rdy),
    .win_data_flat(win_data_flat), .res_vld(res_vld), .res_rdy(res_rdy),
    .res_data(res_data), .fb_wr_en(fb_wr_en), .fb_wr_x(fb_wr_x), .fb_wr_y(fb_wr_y),
    .fb_wr_data(fb_wr_data)
  );

  // ---------------- 1x1 instance ----------------
  logic          start1 = 1'b0;
  logic          busy1, done1, fb_rd_en1, win_vld1, res_rdy1, fb_wr_en1;
  logic [0:0]    fb_rd_x1, fb_rd_y1, fb_wr_x1, fb_wr_y1;
  logic [FW-1:0] win_data_flat1;
  logic [11:0]   fb_wr_data1;
  logic [FW-1:0] rd_const1;
  logic [11:0]   res_const1;
  logic          one = 1'b1;
  logic          zero = 1'b0;

  frame_scan_ctrl #(.IMG_WD(1), .IMG_HT(1), .WIN_WD(3), .WIN_HT(3), .PXL_BITS(12)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(zero), .busy(busy1), .done(done1),
    .fb_rd_en(fb_rd_en1), .fb_rd_x(fb_rd_x1), .fb_rd_y(fb_rd_y1),
    .fb_rd_data_flat(rd_const1), .win_vld(win_vld1), .win_rdy(one),
    .win_data_flat(win_data_flat1), .res_vld(one), .res_rdy(res_rdy1),
    .res_data(res_const1), .fb_wr_en(fb_wr_en1), .fb_wr_x(fb_wr_x1), .fb_wr_y(fb_wr_y1),
    .fb_wr_data(fb_wr_data1)
  );

  // Source pixel i of the window centred on (x, y).
  function automatic logic [11:0] pix(input int x, input int y, input int i);
    int v;
    v = x + 16 * y + 100 * i;
    return v[11:0];
  endfunction

  function automatic logic [FW-1:0] exp_win(input int x, input int y);
    logic [FW-1:0] w;
    w = '0;
    for (int i = 0; i < 9; i++) w[i*12 +: 12] = pix(x, y, i);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Source frame buffer model: window depends only on the read coordinates.
  always_comb begin
    fb_rd_data_flat = '0;
    for (int i = 0; i < 9; i++)
      fb_rd_data_flat[i*12 +: 12] = pix(int'(fb_rd_x), int'(fb_rd_y), i);
  end

  // Kernel model: result is the window's pixel 0, offered the cycle after acceptance.
  logic        res_pend;
  logic [11:0] res_val;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      res_pend <= 1'b0;
      res_val  <= '0;
    end else if (!busy) begin
      res_pend <= 1'b0;
    end else if (win_vld && win_rdy) begin
      res_pend <= 1'b1;
      res_val  <= win_data_flat[11:0];
    end else if (res_vld && res_rdy) begin
      res_pend <= 1'b0;
    end
  end
  assign res_vld = res_pend;
  assign res_data = res_val;

  // Scoreboard: raster order of reads/writes, written data, idle coordinates, exclusivity.
  int   sb_idx = 0, wr_cnt = 0, done_cnt = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      sb_idx    = 0;
      wr_cnt    = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        sb_idx = 0;
        wr_cnt = 0;
      end
      prev_busy = busy;
      if (fb_rd_en) begin
        chk("rd_x", fb_rd_x, sb_idx % 4);
        chk("rd_y", fb_rd_y, sb_idx / 4);
      end else begin
        chk("rd_xy_idle", {fb_rd_x, fb_rd_y}, 0);
      end
      if (fb_wr_en) begin
        chk("wr_x", fb_wr_x, sb_idx % 4);
        chk("wr_y", fb_wr_y, sb_idx / 4);
        chk("wr_data", fb_wr_data, pix(sb_idx % 4, sb_idx / 4, 0));
        sb_idx++;
        wr_cnt++;
      end else begin
        chk("wr_xy_idle", {fb_wr_x, fb_wr_y}, 0);
      end
      chk("excl", ($countones({fb_rd_en, win_vld, res_rdy, fb_wr_en}) <= 1), 1);
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Count observed cycles (starting at n0) until done or budget runs out.
  task automatic wait_done(input int n0, input int budget, output int n, output logic busy_all);
    n = n0;
    busy_all = busy;
    while (!done && n < budget) begin
      tick();
      n++;
      busy_all &= busy;
    end
  endtask

  int   n, d0;
  logic ball, ok;

  initial begin
    rd_const1  = '0;
    for (int i = 0; i < 9; i++) rd_const1[i*12 +: 12] = 12'h123 + 12'(i);
    res_const1 = 12'h5A5;

    // Reset state
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_outs", {done, fb_rd_en, win_vld, res_rdy, fb_wr_en}, 0);
    chk("rst_win", win_data_flat, 0);
    chk("rst_wdata", fb_wr_data, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // 1: full 4x3 scan, zero-wait kernel
    d0 = done_cnt;
    pulse_start();
    chk("t1_busy_first", busy, 1);
    wait_done(1, 200, n, ball);
    chk("t1_done_seen", done, 1);
    chk("t1_latency", n, 49);
    chk("t1_busy_all", ball, 1);
    tick();
    chk("t1_idle", busy, 0);
    chk("t1_wr_cnt", wr_cnt, 12);
    chk("t1_done_cnt", done_cnt - d0, 1);

    // 2: kernel stalls at (2,1)
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      ok = fb_rd_en && (fb_rd_x == 2'd2) && (fb_rd_y == 2'd1);
      if (!ok) tick();
    end
    chk("t2_reach_21", ok, 1);
    win_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_vld", win_vld, 1);
      chk("t2_win", win_data_flat, exp_win(2, 1));
      chk("t2_no_rw", {fb_rd_en, fb_wr_en}, 0);
    end
    win_rdy = 1'b1;
    wait_done(0, 200, n, ball);
    chk("t2_done_seen", done, 1);
    tick();
    chk("t2_wr_cnt", wr_cnt, 12);

    // 3: abort in WAIT_RES at (1,1), then rescan
    d0 = done_cnt;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      ok = res_rdy && (wr_cnt == 5);
      if (!ok) tick();
    end
    chk("t3_reach_11", ok, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3_idle", busy, 0);
    repeat (4) tick();
    chk("t3_wr_cnt", wr_cnt, 5);
    chk("t3_no_done", done_cnt - d0, 0);
    pulse_start();
    wait_done(1, 200, n, ball);
    chk("t3_rescan_lat", n, 49);
    tick();
    chk("t3_rescan_wr", wr_cnt, 12);

    // 5a: start with abort in IDLE is ignored
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("t5_sa_busy", busy, 0);
    tick();
    chk("t5_sa_busy2", busy, 0);

    // 5b: start while busy is ignored
    d0 = done_cnt;
    pulse_start();
    repeat (9) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(11, 200, n, ball);
    chk("t5_latency", n, 49);
    repeat (3) tick();
    chk("t5_done_cnt", done_cnt - d0, 1);
    chk("t5_wr_cnt", wr_cnt, 12);
    chk("t5_idle", busy, 0);

    // 4: async reset mid-PRESENT
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = win_vld;
      if (!ok) tick();
    end
    chk("t4_present", ok, 1);
    win_rdy = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("t4_busy", busy, 0);
    chk("t4_vld", win_vld, 0);
    chk("t4_win", win_data_flat, 0);
    chk("t4_wdata", fb_wr_data, 0);
    #3 rst = 1'b0;
    win_rdy = 1'b1;
    repeat (3) begin
      tick();
      chk("t4_stay_idle", busy, 0);
    end

    // 6: 1x1 frame
    tick();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("t6_read", fb_rd_en1, 1);
    tick();
    chk("t6_present", win_vld1, 1);
    chk("t6_win", win_data_flat1, rd_const1);
    tick();
    chk("t6_wait", res_rdy1, 1);
    tick();
    chk("t6_write", fb_wr_en1, 1);
    chk("t6_wr_xy", {fb_wr_x1, fb_wr_y1}, 0);
    chk("t6_wr_data", fb_wr_data1, 12'h5A5);
    tick();
    chk("t6_done", done1, 1);
    tick();
    chk("t6_idle", {busy1, done1}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
